// File: rtl/neuron_layer_sequencer_if.sv
// Bus bundle between the layer sequencer, the layer controller, operand/bias memories and the neuron unit.
// The cycle_cnt signal is present only when SEQ_PERF_CNT_EN is defined.
interface neuron_layer_sequencer_if #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = 11
);
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [N_NEURONS-1:0] out_vec;
  logic                 mem_rd_en;
  logic [ADDR_W-1:0]    mem_addr;
  logic [11:0]          mem_rdata;
  logic                 bias_rd_en;
  logic [7:0]           bias_addr;
  logic [12:0]          bias_rdata;
  logic [107:0]         ac_in;
  logic [12:0]          ac_bias;
  logic                 ac_out;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0]          cycle_cnt;

  modport master (
    input  start, abort, mem_rdata, bias_rdata, ac_out,
    output busy, done, out_vec, mem_rd_en, mem_addr, bias_rd_en, bias_addr,
           ac_in, ac_bias, cycle_cnt
  );

  modport slave (
    output start, abort, mem_rdata, bias_rdata, ac_out,
    input  busy, done, out_vec, mem_rd_en, mem_addr, bias_rd_en, bias_addr,
           ac_in, ac_bias, cycle_cnt
  );
`else
  modport master (
    input  start, abort, mem_rdata, bias_rdata, ac_out,
    output busy, done, out_vec, mem_rd_en, mem_addr, bias_rd_en, bias_addr,
           ac_in, ac_bias
  );

  modport slave (
    output start, abort, mem_rdata, bias_rdata, ac_out,
    input  busy, done, out_vec, mem_rd_en, mem_addr, bias_rd_en, bias_addr,
           ac_in, ac_bias
  );
`endif
endinterface

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one shared 9-input neuron unit over N_NEURONS neurons, collecting results in out_vec.
// Define SEQ_PERF_CNT_EN to add the saturating busy-cycle counter cycle_cnt.
module neuron_layer_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int ADDR_W    = 11,
  parameter int CMP_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_layer_sequencer_if.master bus
);

  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int LW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [NW-1:0] LAST_NEURON = NW'(N_NEURONS - 1);
  localparam logic [LW-1:0] LAST_WAIT   = LW'(CMP_LAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]           state;
  logic [NW-1:0]        neuron;
  logic [3:0]           k;
  logic [LW-1:0]        wait_cnt;
  logic [ADDR_W-1:0]    addr_cnt;
  logic [N_NEURONS-1:0] out_vec;
  logic [107:0]         ac_in;
  logic [12:0]          ac_bias;
  logic                 capture;
  logic [3:0]           cap_idx;

  // Operands of a neuron are contiguous, so the address simply runs 0..9*N-1 across the layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      neuron   <= '0;
      k        <= '0;
      wait_cnt <= '0;
      addr_cnt <= '0;
      out_vec  <= '0;
    end else if (bus.abort && (state != S_IDLE)) begin
      state   <= S_IDLE;
      out_vec <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_FETCH;
            neuron   <= '0;
            k        <= '0;
            addr_cnt <= '0;
            out_vec  <= '0;
          end
        end
        S_FETCH: begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
          if (k == 4'd8) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_DRAIN: begin
          wait_cnt <= '0;
          state    <= S_EVAL;
        end
        S_EVAL: begin
          if (wait_cnt == LAST_WAIT) begin
            state <= S_STORE;
          end else begin
            wait_cnt <= wait_cnt + LW'(1);
          end
        end
        S_STORE: begin
          for (int i = 0; i < N_NEURONS; i++) begin
            if (neuron == NW'(i)) begin
              out_vec[i] <= bus.ac_out;
            end
          end
          if (neuron == LAST_NEURON) begin
            state <= S_DONE;
          end else begin
            neuron <= neuron + NW'(1);
            k      <= '0;
            state  <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory data lags its read by one cycle: read k lands in the k+1 cycle, read 8 in DRAIN.
  assign capture = ((state == S_FETCH) && (k != 4'd0)) || (state == S_DRAIN);
  assign cap_idx = (state == S_DRAIN) ? 4'd8 : (k - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_in   <= '0;
      ac_bias <= '0;
    end else begin
      if (capture) begin
        for (int i = 0; i < 9; i++) begin
          if (cap_idx == 4'(i)) begin
            ac_in[i*12 +: 12] <= bus.mem_rdata;
          end
        end
      end
      if ((state == S_FETCH) && (k == 4'd1)) begin
        ac_bias <= bus.bias_rdata;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if ((state == S_IDLE) && bus.start) begin
      cycle_cnt <= '0;
    end else if ((state != S_IDLE) && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt;
`endif

  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.out_vec    = out_vec;
  assign bus.mem_rd_en  = (state == S_FETCH);
  assign bus.mem_addr   = (state == S_FETCH) ? addr_cnt : '0;
  assign bus.bias_rd_en = (state == S_FETCH) && (k == 4'd0);
  assign bus.bias_addr  = ((state == S_FETCH) && (k == 4'd0)) ? 8'(neuron) : 8'd0;
  assign bus.ac_in      = ac_in;
  assign bus.ac_bias    = ac_bias;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench: random operand/bias memories, a latency-accurate neuron unit and a sum>bias model.
// Define SEQ_PERF_CNT_EN to also exercise cycle_cnt.
module tb_neuron_layer_sequencer;

  localparam int N         = 2;
  localparam int AW        = 11;
  localparam int LAT       = 1;
  localparam int LAYER_CYC = N * (11 + LAT) + 1;
  localparam int BUDGET    = LAYER_CYC + 50;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  neuron_layer_sequencer_if #(.N_NEURONS(N), .ADDR_W(AW)) bus_if ();

  neuron_layer_sequencer #(.N_NEURONS(N), .ADDR_W(AW), .CMP_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [11:0]    op_mem   [0:(1<<AW)-1];
  logic [12:0]    bias_mem [0:255];
  logic [LAT-1:0] unit_pipe = '0;
  int             addr_q[$];
  int             bias_q[$];
  int             done_cnt = 0;

  function automatic logic unit_cmp(input logic [107:0] ops, input logic [12:0] b);
    int unsigned s = 0;
    for (int j = 0; j < 9; j++) s += 32'(ops[j*12 +: 12]);
    return s > 32'(b);
  endfunction

  // Memories answer one cycle after the strobe; the neuron unit result trails stable inputs by LAT cycles.
  always @(posedge clk) begin
    if (bus_if.mem_rd_en)  bus_if.mem_rdata  <= op_mem[bus_if.mem_addr];
    if (bus_if.bias_rd_en) bus_if.bias_rdata <= bias_mem[bus_if.bias_addr];
    for (int j = LAT - 1; j > 0; j--) unit_pipe[j] <= unit_pipe[j-1];
    unit_pipe[0] <= unit_cmp(bus_if.ac_in, bus_if.ac_bias);
  end

  assign bus_if.ac_out = unit_pipe[LAT-1];

  always @(negedge clk) begin
    if (bus_if.mem_rd_en)  addr_q.push_back(int'(bus_if.mem_addr));
    if (bus_if.bias_rd_en) bias_q.push_back(int'(bus_if.bias_addr));
    if (bus_if.done)       done_cnt++;
  end

  function automatic logic [N-1:0] model_out();
    logic [N-1:0] r;
    int unsigned  s;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < 9; j++) s += 32'(op_mem[i*9 + j]);
      r[i] = (s > 32'(bias_mem[i]));
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 9 * N; i++) op_mem[i] = 12'($urandom_range(0, 1800));
    for (int i = 0; i < N; i++) bias_mem[i] = 13'($urandom_range(0, 8191));
  endtask

  task automatic start_layer(input bit hold);
    addr_q.delete();
    bias_q.delete();
    done_cnt = 0;
    bus_if.start = 1'b1;
    tick();
    if (!hold) bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int first_cyc, output int dc);
    int cyc = first_cyc;
    dc = -1;
    while ((cyc <= BUDGET) && (dc < 0)) begin
      if (bus_if.done === 1'b1) dc = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    n_checks++;
    if (dc < 0) begin
      n_fail++;
      $display("[TB] FAIL done_timeout: no done after %0d cycles, required within %0d", cyc, BUDGET);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.mem_rd_en, bus_if.bias_rd_en} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes: got %b required 0000",
               {bus_if.busy, bus_if.done, bus_if.mem_rd_en, bus_if.bias_rd_en});
    end
    n_checks++;
    if (bus_if.out_vec !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_out_vec: got %b required 0", bus_if.out_vec);
    end
    n_checks++;
    if ((bus_if.mem_addr !== '0) || (bus_if.bias_addr !== '0)) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got %0h/%0h required 0/0", bus_if.mem_addr, bus_if.bias_addr);
    end
    n_checks++;
    if ((bus_if.ac_in !== '0) || (bus_if.ac_bias !== '0)) begin
      n_fail++;
      $display("[TB] FAIL reset_ac: got %0h/%0h required 0/0", bus_if.ac_in, bus_if.ac_bias);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_addr_timing();
    int dc;
    int bad = 0;
    logic [N-1:0] expv;
    fill_random();
    expv = model_out();
    start_layer(1'b0);
    wait_done(1, dc);
    n_checks++;
    if (dc != LAYER_CYC) begin
      n_fail++;
      $display("[TB] FAIL done_latency: got cycle %0d required %0d", dc, LAYER_CYC);
    end
    if (addr_q.size() != 9 * N) bad++;
    else for (int i = 0; i < 9 * N; i++) if (addr_q[i] != i) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL addr_seq: got %0d reads with %0d bad, required %0d in order", addr_q.size(), bad, 9 * N);
    end
    bad = 0;
    if (bias_q.size() != N) bad++;
    else for (int i = 0; i < N; i++) if (bias_q[i] != i) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL bias_seq: got %0d reads with %0d bad, required %0d in order", bias_q.size(), bad, N);
    end
    n_checks++;
    if ((done_cnt != 1) || (bus_if.busy !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL done_pulse: got %0d pulses busy=%b, required 1 pulse busy=0", done_cnt, bus_if.busy);
    end
    n_checks++;
    if (bus_if.out_vec !== expv) begin
      n_fail++;
      $display("[TB] FAIL out_vec_first: got %b required %b", bus_if.out_vec, expv);
    end
  endtask

  task automatic test_known_pattern();
    int dc;
    logic [N-1:0] expv;
    for (int i = 0; i < 9 * N; i++) op_mem[i] = 12'h001;
    for (int i = 0; i < N; i++) begin
      bias_mem[i] = (i % 2 == 0) ? 13'd8 : 13'd9;
      expv[i]     = (i % 2 == 0);
    end
    start_layer(1'b0);
    wait_done(1, dc);
    n_checks++;
    if (bus_if.out_vec !== expv) begin
      n_fail++;
      $display("[TB] FAIL out_vec_ones: got %b required %b", bus_if.out_vec, expv);
    end
  endtask

  task automatic test_random();
    int dc;
    logic [N-1:0] expv;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      expv = model_out();
      start_layer(1'b0);
      wait_done(1, dc);
      n_checks++;
      if ((bus_if.out_vec !== expv) || (dc != LAYER_CYC)) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: got out_vec %b at cycle %0d, required %b at %0d",
                 it, bus_if.out_vec, dc, expv, LAYER_CYC);
      end
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (bus_if.out_vec !== expv) begin
      n_fail++;
      $display("[TB] FAIL out_vec_hold: got %b required %b", bus_if.out_vec, expv);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [N-1:0] expv;
    fill_random();
    expv = model_out();
    start_layer(1'b1);
    wait_done(1, dc);
    n_checks++;
    if ((dc != LAYER_CYC) || (done_cnt != 1) || (addr_q.size() != 9 * N)) begin
      n_fail++;
      $display("[TB] FAIL held_first: got cycle %0d, %0d dones, %0d reads; required %0d, 1, %0d",
               dc, done_cnt, addr_q.size(), LAYER_CYC, 9 * N);
    end
    n_checks++;
    if ((bus_if.busy !== 1'b0) || (bus_if.out_vec !== expv)) begin
      n_fail++;
      $display("[TB] FAIL held_idle: got busy=%b out_vec=%b, required busy=0 out_vec=%b",
               bus_if.busy, bus_if.out_vec, expv);
    end
    tick();
    bus_if.start = 1'b0;
    done_cnt = 0;
    n_checks++;
    if ((bus_if.busy !== 1'b1) || (bus_if.mem_addr !== '0) || (bus_if.out_vec !== '0)) begin
      n_fail++;
      $display("[TB] FAIL held_restart: got busy=%b addr=%0d out_vec=%b, required 1/0/0",
               bus_if.busy, bus_if.mem_addr, bus_if.out_vec);
    end
    wait_done(1, dc);
    n_checks++;
    if ((dc != LAYER_CYC) || (done_cnt != 1) || (bus_if.out_vec !== expv)) begin
      n_fail++;
      $display("[TB] FAIL held_second: got cycle %0d, %0d dones, out_vec %b; required %0d, 1, %b",
               dc, done_cnt, bus_if.out_vec, LAYER_CYC, expv);
    end
  endtask

  task automatic test_abort();
    int dc;
    int bad = 0;
    logic [N-1:0] expv;
    fill_random();
    expv = model_out();
    start_layer(1'b0);
    for (int c = 1; c < (11 + LAT) + 11; c++) tick();
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    n_checks++;
    if ((bus_if.busy !== 1'b0) || (bus_if.out_vec !== '0) || (bus_if.mem_rd_en !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL abort_eval: got busy=%b out_vec=%b rd=%b, required 0/0/0",
               bus_if.busy, bus_if.out_vec, bus_if.mem_rd_en);
    end
    for (int c = 0; c < LAYER_CYC; c++) tick();
    n_checks++;
    if ((done_cnt != 0) || (bus_if.busy !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done: got %0d dones busy=%b, required 0 dones busy=0", done_cnt, bus_if.busy);
    end
    bus_if.abort = 1'b1;
    start_layer(1'b0);
    bus_if.abort = 1'b0;
    n_checks++;
    if ((bus_if.busy !== 1'b1) || (bus_if.mem_addr !== '0)) begin
      n_fail++;
      $display("[TB] FAIL start_beats_abort: got busy=%b addr=%0d, required 1/0", bus_if.busy, bus_if.mem_addr);
    end
    wait_done(1, dc);
    if (addr_q.size() != 9 * N) bad++;
    else for (int i = 0; i < 9 * N; i++) if (addr_q[i] != i) bad++;
    n_checks++;
    if ((bad != 0) || (bus_if.out_vec !== expv) || (dc != LAYER_CYC)) begin
      n_fail++;
      $display("[TB] FAIL after_abort: got %0d bad addrs out_vec %b cycle %0d, required 0, %b, %0d",
               bad, bus_if.out_vec, dc, expv, LAYER_CYC);
    end
    start_layer(1'b0);
    for (int c = 1; c < 4; c++) tick();
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    n_checks++;
    if ((bus_if.mem_rd_en !== 1'b0) || (bus_if.bias_rd_en !== 1'b0) || (bus_if.busy !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL abort_fetch: got rd=%b bias_rd=%b busy=%b, required 0/0/0",
               bus_if.mem_rd_en, bus_if.bias_rd_en, bus_if.busy);
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    start_layer(1'b0);
    for (int c = 1; c < 5; c++) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.busy, bus_if.done, bus_if.mem_rd_en, bus_if.bias_rd_en} !== 4'b0 ||
        (bus_if.mem_addr !== '0) || (bus_if.out_vec !== '0)) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_ctrl: got busy=%b rd=%b addr=%0d out_vec=%b, required all 0",
               bus_if.busy, bus_if.mem_rd_en, bus_if.mem_addr, bus_if.out_vec);
    end
    n_checks++;
    if ((bus_if.ac_in !== '0) || (bus_if.ac_bias !== '0)) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_ac: got %0h/%0h required 0/0", bus_if.ac_in, bus_if.ac_bias);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAYER_CYC; c++) tick();
    n_checks++;
    if ((done_cnt != 0) || (bus_if.busy !== 1'b0)) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_idle: got %0d dones busy=%b, required 0/0", done_cnt, bus_if.busy);
    end
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf_cnt();
    int dc;
    fill_random();
    start_layer(1'b0);
    wait_done(1, dc);
    n_checks++;
    if (bus_if.cycle_cnt !== 16'(LAYER_CYC)) begin
      n_fail++;
      $display("[TB] FAIL cycle_cnt_done: got %0d required %0d", bus_if.cycle_cnt, LAYER_CYC);
    end
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (bus_if.cycle_cnt !== 16'(LAYER_CYC)) begin
      n_fail++;
      $display("[TB] FAIL cycle_cnt_hold: got %0d required %0d", bus_if.cycle_cnt, LAYER_CYC);
    end
    start_layer(1'b0);
    n_checks++;
    if (bus_if.cycle_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL cycle_cnt_clear: got %0d required 0", bus_if.cycle_cnt);
    end
    wait_done(1, dc);
    n_checks++;
    if (bus_if.cycle_cnt !== 16'(LAYER_CYC)) begin
      n_fail++;
      $display("[TB] FAIL cycle_cnt_rerun: got %0d required %0d", bus_if.cycle_cnt, LAYER_CYC);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    test_reset();
    test_addr_timing();
    test_known_pattern();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef SEQ_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
